mimi_wb_master: RTL and testbench
=================================

// Module: mimi_wb_master
// PURPOSE
// - Wishbone classic initiator: turns a minimax-style data request (addr/wdata/wmask, we) into one
//   single-beat Wishbone cycle; returns read data or error. Lets the core reach peripherals outside mimi's SRAM.
// - One transaction outstanding; FSM with registered bus outputs; optional bus-timeout abort.
// PARAMETERS
// - ADDR_WIDTH      32   width of req_addr / wbm_adr_o
// - TIMEOUT_CYCLES  255  max cycles in BUS before abort (MIMI_WBM_TIMEOUT_EN only); legal 1..65535
// PORTS
// - wb_clk_i   in   1   single clock; all logic on posedge
// - wb_rst_i   in   1   asynchronous, active-high reset
// - req_valid  in   1   core request; sampled only while req_ready=1
// - req_ready  out  1   1 only in IDLE
// - req_we     in   1   1=write, 0=read
// - req_addr   in   ADDR_WIDTH  byte address; bits [1:0] ignored
// - req_wdata  in   32  write data
// - req_wmask  in   4   byte enables for writes
// - rsp_valid  out  1   one-cycle pulse on completion
// - rsp_rdata  out  32  read data, valid with rsp_valid (0 for writes and errors)
// - rsp_err    out  1   1 = bus error or timeout, valid with rsp_valid
// - wbm_cyc_o, wbm_stb_o  out 1   cycle/strobe, always asserted/deasserted together
// - wbm_we_o   out  1   write enable
// - wbm_sel_o  out  4   byte selects
// - wbm_adr_o  out  ADDR_WIDTH  {req_addr[ADDR_WIDTH-1:2],2'b00}
// - wbm_dat_o  out  32  write data
// - wbm_dat_i  in   32  read data from target
// - wbm_ack_i  in   1   normal termination
// - wbm_err_i  in   1   error termination
// BEHAVIOUR
// - Reset (async assert, sync to clock on release): state=IDLE; every output 0 except req_ready=1.
// - States: IDLE, BUS, RESP.
// - IDLE: req_ready=1. req_valid=1 at edge -> latch adr/dat/we; sel = req_we ? req_wmask : 4'hF;
//   -> BUS. wbm_cyc_o/stb_o go 1 after that same edge (registered).
// - Write with req_wmask=4'h0: still issued, sel=0 (target must ack).
// - BUS: cyc/stb/adr/sel/we/dat_o held stable until termination.
//   wbm_err_i=1 -> rsp_err=1, rsp_rdata=0; else wbm_ack_i=1 -> rsp_err=0, rsp_rdata=we?0:wbm_dat_i.
//   ack and err same cycle: err wins. On termination edge: cyc/stb->0, rsp_valid->1, -> RESP.
// - RESP: one cycle; rsp_valid=1, req_ready=0; -> IDLE. rsp_valid then 0; rsp_rdata/rsp_err hold until next rsp.
// - Latency: accept edge E; cyc high cycles E+1..; zero-wait target acks in first cycle -> rsp_valid
//   in cycle E+2, req_ready in E+3. Bus idles >=2 cycles between transactions.
// - ack/err seen in IDLE or RESP: ignored, no response.
// - Reset mid-transaction: cyc/stb drop immediately (async); pending request discarded; no rsp_valid.
// CONFIGURATION
// - MIMI_WBM_TIMEOUT_EN defined: counter clears on entry to BUS, +1 per BUS cycle without termination;
//   on the edge ending the TIMEOUT_CYCLES-th such cycle: cyc/stb->0, rsp_err=1, rsp_rdata=0, -> RESP.
//   Termination in the last cycle beats timeout (normal ack/err response).
// - Undefined: no counter logic; BUS waits indefinitely for ack/err.
// TESTING
// - Read 0x3000_0010, target acks 1st cycle with 0xCAFE_F00D -> cyc 1 cycle, sel=F, rsp_valid E+2, rdata=CAFE_F00D, err=0.
// - Write 0x3000_0007, wdata 0x1234_5678, wmask=4'h3, ack after 3 waits -> adr=0x3000_0004, sel=3, we=1, 4 cyc cycles, rsp err=0 rdata=0.
// - ack+err same cycle on read -> rsp_err=1, rsp_rdata=0; a later req_valid is accepted only once req_ready=1.
// - Reset asserted mid-BUS -> cyc/stb/rsp_valid=0 same cycle, req_ready=1 after release, stray ack ignored.
// - TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> cyc high exactly 4 cycles, rsp_err=1; ack in 4th cycle -> normal rsp.
// - Back-to-back: req_valid held high for 3 reads -> 3 transactions, each with >=2 idle bus cycles between, in order.

Source files
------------

// File: rtl/mimi_wb_master.sv
// Wishbone classic single-beat initiator that bridges mimi's data requests to off-SRAM peripherals.
// Optional bus-timeout abort is enabled by defining MIMI_WBM_TIMEOUT_EN.
module mimi_wb_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_wmask,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [3:0]            wbm_sel_o,
  output logic [ADDR_WIDTH-1:0] wbm_adr_o,
  output logic [31:0]           wbm_dat_o,
  input  logic [31:0]           wbm_dat_i,
  input  logic                  wbm_ack_i,
  input  logic                  wbm_err_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t                  state, state_nx;
  logic                    cyc_q, cyc_nx;
  logic                    we_nx;
  logic [3:0]              sel_nx;
  logic [ADDR_WIDTH-1:0]   adr_nx;
  logic [31:0]             dat_nx;
  logic                    rsp_valid_nx;
  logic [31:0]             rsp_rdata_nx;
  logic                    rsp_err_nx;
  logic                    timeout_hit;

  // Byte-lane bits of the request address never reach the bus.
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^req_addr[1:0];

`ifdef MIMI_WBM_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] to_cnt;

  // Counts completed BUS cycles; idles at zero so every bus cycle starts fresh.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      to_cnt <= '0;
    end else if (state != BUS) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 16'd1;
    end
  end

  assign timeout_hit = (to_cnt == TO_LAST);
`else
  logic timeout_cfg_unused;
  assign timeout_cfg_unused = (TIMEOUT_CYCLES > 0);
  assign timeout_hit        = 1'b0;
`endif

  assign req_ready = (state == IDLE);
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      cyc_q     <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'h0;
      wbm_adr_o <= '0;
      wbm_dat_o <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      cyc_q     <= cyc_nx;
      wbm_we_o  <= we_nx;
      wbm_sel_o <= sel_nx;
      wbm_adr_o <= adr_nx;
      wbm_dat_o <= dat_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_rdata <= rsp_rdata_nx;
      rsp_err   <= rsp_err_nx;
    end
  end

  // Bus signals hold their value unless the FSM explicitly changes them.
  always_comb begin
    state_nx     = state;
    cyc_nx       = cyc_q;
    we_nx        = wbm_we_o;
    sel_nx       = wbm_sel_o;
    adr_nx       = wbm_adr_o;
    dat_nx       = wbm_dat_o;
    rsp_valid_nx = 1'b0;
    rsp_rdata_nx = rsp_rdata;
    rsp_err_nx   = rsp_err;

    case (state)
      IDLE: begin
        if (req_valid) begin
          cyc_nx   = 1'b1;
          we_nx    = req_we;
          sel_nx   = req_we ? req_wmask : 4'hF;
          adr_nx   = {req_addr[ADDR_WIDTH-1:2], 2'b00};
          dat_nx   = req_wdata;
          state_nx = BUS;
        end
      end

      BUS: begin
        if (wbm_err_i) begin
          cyc_nx       = 1'b0;
          rsp_valid_nx = 1'b1;
          rsp_err_nx   = 1'b1;
          rsp_rdata_nx = 32'h0;
          state_nx     = RESP;
        end else if (wbm_ack_i) begin
          cyc_nx       = 1'b0;
          rsp_valid_nx = 1'b1;
          rsp_err_nx   = 1'b0;
          rsp_rdata_nx = wbm_we_o ? 32'h0 : wbm_dat_i;
          state_nx     = RESP;
        end else if (timeout_hit) begin
          cyc_nx       = 1'b0;
          rsp_valid_nx = 1'b1;
          rsp_err_nx   = 1'b1;
          rsp_rdata_nx = 32'h0;
          state_nx     = RESP;
        end
      end

      RESP: begin
        state_nx = IDLE;
      end

      default: begin
        cyc_nx   = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mimi_wb_master.sv
// Self-checking bench for mimi_wb_master: directed vector table, hand sequences, random transactions.
// Timeout sequence runs only when MIMI_WBM_TIMEOUT_EN is defined (TIMEOUT_CYCLES=4 here).
module tb_mimi_wb_master;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = 32'h0;
  logic [3:0]    req_wmask = 4'h0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]    wbm_sel_o;
  logic [AW-1:0] wbm_adr_o;
  logic [31:0]   wbm_dat_o;
  logic [31:0]   wbm_dat_i = 32'h0;
  logic          wbm_ack_i = 1'b0;
  logic          wbm_err_i = 1'b0;

  always #5 clk = ~clk;

  mimi_wb_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          waits;
    logic        ack;
    logic        err;
    logic [31:0] tdata;
    logic [31:0] exp_adr;
    logic [3:0]  exp_sel;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs[NV];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One full transaction, entered and left at a negedge with the DUT idle.
  task automatic applyStimulus(input string tag, input vec_t v);
    checkOutput({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_wmask = v.wmask;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    checkOutput({tag, "_cycstb"}, 32'({wbm_cyc_o, wbm_stb_o}), 32'd3);
    checkOutput({tag, "_adr"}, wbm_adr_o, v.exp_adr);
    checkOutput({tag, "_sel"}, 32'(wbm_sel_o), 32'(v.exp_sel));
    checkOutput({tag, "_we"}, 32'(wbm_we_o), 32'(v.we));
    if (v.we) checkOutput({tag, "_dat_o"}, wbm_dat_o, v.wdata);
    checkOutput({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
    for (int i = 0; i < v.waits; i++) begin
      @(posedge clk); @(negedge clk);
      checkOutput({tag, "_cyc_wait"}, 32'({wbm_cyc_o, wbm_stb_o}), 32'd3);
      checkOutput({tag, "_adr_hold"}, wbm_adr_o, v.exp_adr);
      checkOutput({tag, "_vld_wait"}, 32'(rsp_valid), 32'd0);
    end
    wbm_ack_i = v.ack;
    wbm_err_i = v.err;
    wbm_dat_i = v.tdata;
    @(posedge clk); @(negedge clk);
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_dat_i = $urandom;
    checkOutput({tag, "_cyc_off"}, 32'({wbm_cyc_o, wbm_stb_o}), 32'd0);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    checkOutput({tag, "_rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
    checkOutput({tag, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
    checkOutput({tag, "_ready_resp"}, 32'(req_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    checkOutput({tag, "_vld_drop"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_rdata_hold"}, rsp_rdata, v.exp_rdata);
    checkOutput({tag, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  // Reference model: expected bus and response values straight from the transaction rules.
  function automatic vec_t ref_model(input vec_t v);
    vec_t r;
    r           = v;
    r.exp_adr   = v.addr & 32'hFFFF_FFFC;
    r.exp_sel   = v.we ? v.wmask : 4'hF;
    r.exp_err   = v.err;
    r.exp_rdata = (v.err || v.we) ? 32'h0 : v.tdata;
    return r;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run still active at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        rv;
    logic [31:0] b2b_addr[3];
    logic [31:0] b2b_data[3];
    int          issued, got, gap, cnt;
    logic        prev_cyc;

    vecs[0] = '{1'b0, 32'h3000_0010, 32'h0,         4'h0, 0, 1'b1, 1'b0, 32'hCAFE_F00D,
                32'h3000_0010, 4'hF, 32'hCAFE_F00D, 1'b0};
    vecs[1] = '{1'b1, 32'h3000_0007, 32'h1234_5678, 4'h3, 3, 1'b1, 1'b0, 32'hAAAA_5555,
                32'h3000_0004, 4'h3, 32'h0, 1'b0};
    vecs[2] = '{1'b0, 32'h1000_0002, 32'h0,         4'h0, 1, 1'b1, 1'b1, 32'hDEAD_BEEF,
                32'h1000_0000, 4'hF, 32'h0, 1'b1};
    vecs[3] = '{1'b1, 32'h2000_000C, 32'h0BAD_F00D, 4'h0, 0, 1'b1, 1'b0, 32'h7777_7777,
                32'h2000_000C, 4'h0, 32'h0, 1'b0};
    vecs[4] = '{1'b1, 32'h5000_0101, 32'h8765_4321, 4'hC, 1, 1'b0, 1'b1, 32'h1111_2222,
                32'h5000_0100, 4'hC, 32'h0, 1'b1};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'h0,         4'h5, 2, 1'b1, 1'b0, 32'h0123_4567,
                32'hFFFF_FFFC, 4'hF, 32'h0123_4567, 1'b0};

    #2 rst = 1'b1;
    #1;
    checkOutput("rst_cycstb", 32'({wbm_cyc_o, wbm_stb_o}), 32'd0);
    checkOutput("rst_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rdata", rsp_rdata, 32'h0);
    checkOutput("rst_bus", {wbm_adr_o[31:0] | wbm_dat_o}, 32'h0);
    checkOutput("rst_sel_we_err", 32'({wbm_sel_o, wbm_we_o, rsp_err}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed vector table");
    for (int i = 0; i < NV; i++) applyStimulus($sformatf("vec%0d", i), vecs[i]);

    $display("[TB] stray ack/err while idle");
    wbm_ack_i = 1'b1;
    wbm_err_i = 1'b1;
    wbm_dat_i = 32'h5A5A_5A5A;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      checkOutput("stray_idle_vld", 32'(rsp_valid), 32'd0);
      checkOutput("stray_idle_cyc", 32'(wbm_cyc_o), 32'd0);
      checkOutput("stray_idle_rdata", rsp_rdata, vecs[NV-1].exp_rdata);
      checkOutput("stray_idle_err", 32'(rsp_err), 32'(vecs[NV-1].exp_err));
    end
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;

    $display("[TB] reset in the middle of a bus cycle");
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h3000_0040;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("midrst_cyc_before", 32'(wbm_cyc_o), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_cycstb", 32'({wbm_cyc_o, wbm_stb_o}), 32'd0);
    checkOutput("midrst_vld", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h9999_0000;
    @(posedge clk); @(negedge clk);
    wbm_ack_i = 1'b0;
    checkOutput("midrst_stray_vld", 32'(rsp_valid), 32'd0);
    checkOutput("midrst_ready", 32'(req_ready), 32'd1);
    checkOutput("midrst_cyc_after", 32'(wbm_cyc_o), 32'd0);

`ifdef MIMI_WBM_TIMEOUT_EN
    $display("[TB] timeout abort with no target response");
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h3000_0080;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!wbm_cyc_o) break;
      cnt++;
      @(posedge clk); @(negedge clk);
    end
    checkOutput("to_cyc_cycles", 32'(cnt), 32'd4);
    checkOutput("to_vld", 32'(rsp_valid), 32'd1);
    checkOutput("to_err", 32'(rsp_err), 32'd1);
    checkOutput("to_rdata", rsp_rdata, 32'h0);
    @(posedge clk); @(negedge clk);
`else
    $display("[TB] slow target: bus cycle held open for 20 cycles");
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h3000_0080;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("slow_cyc_held", 32'({wbm_cyc_o, wbm_stb_o}), 32'd3);
    checkOutput("slow_vld", 32'(rsp_valid), 32'd0);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hBEEF_0001;
    @(posedge clk); @(negedge clk);
    wbm_ack_i = 1'b0;
    checkOutput("slow_vld_done", 32'(rsp_valid), 32'd1);
    checkOutput("slow_rdata", rsp_rdata, 32'hBEEF_0001);
    checkOutput("slow_err", 32'(rsp_err), 32'd0);
    @(posedge clk); @(negedge clk);
`endif

    $display("[TB] back-to-back reads with req_valid held high");
    b2b_addr[0] = 32'h4000_0000; b2b_addr[1] = 32'h4000_0104; b2b_addr[2] = 32'h4000_0208;
    b2b_data[0] = 32'h1111_1111; b2b_data[1] = 32'h2222_2222; b2b_data[2] = 32'h3333_3333;
    issued   = 0;
    got      = 0;
    gap      = 0;
    prev_cyc = 1'b0;
    req_we    = 1'b0;
    req_addr  = b2b_addr[0];
    req_valid = 1'b1;
    for (int c = 0; c < 40 && got < 3; c++) begin
      @(posedge clk); @(negedge clk);
      if (wbm_cyc_o && !prev_cyc) begin
        if (issued > 0) checkOutput("b2b_gap_ge2", 32'(gap >= 2), 32'd1);
        if (issued < 3) begin
          checkOutput("b2b_adr", wbm_adr_o, b2b_addr[issued]);
          wbm_dat_i = b2b_data[issued];
        end
        wbm_ack_i = 1'b1;
        issued++;
        if (issued < 3) req_addr = b2b_addr[issued];
        else req_valid = 1'b0;
      end
      if (!wbm_cyc_o) begin
        gap++;
        wbm_ack_i = 1'b0;
      end else begin
        gap = 0;
      end
      if (rsp_valid) begin
        if (got < 3) checkOutput("b2b_rdata", rsp_rdata, b2b_data[got]);
        got++;
      end
      prev_cyc = wbm_cyc_o;
    end
    req_valid = 1'b0;
    wbm_ack_i = 1'b0;
    checkOutput("b2b_rsp_count", 32'(got), 32'd3);
    checkOutput("b2b_issue_count", 32'(issued), 32'd3);
    repeat (2) @(negedge clk);

    $display("[TB] randomized transactions against reference model");
    for (int n = 0; n < 30; n++) begin
      int outcome;
      rv.we    = 1'($urandom_range(0, 1));
      rv.addr  = $urandom;
      rv.wdata = $urandom;
      rv.wmask = 4'($urandom_range(0, 15));
      rv.waits = $urandom_range(0, 3);
      rv.tdata = $urandom;
      outcome  = $urandom_range(0, 3);
      rv.ack   = (outcome != 2);
      rv.err   = (outcome >= 2);
      applyStimulus($sformatf("rnd%0d", n), ref_model(rv));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
